// File: rtl/mc_seq_controller.sv
// Multicycle ARM sequencing controller: merged decode, condition check and main FSM,
// with an iterative multiply handshake guarded by a timeout.
module mc_seq_controller #(
    parameter bit ENABLE_MUL  = 1'b1,
    parameter int MUL_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MulDone,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        MulRead,
    output logic        WA3Src,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        MulStart,
    output logic        MulSigned,
    output logic        MulHi,
    output logic        Fault
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC += 4
    // DECODE   | evaluate condition, pick instruction path
    // EXECR    | ALU op with register operand B
    // EXECI    | ALU op with immediate operand B
    // ALUWB    | write ALU result to Rd (or PC)
    // MEMADR   | compute load/store address
    // MEMRD    | read data memory
    // MEMWB    | write loaded data to Rd (or PC)
    // MEMWR    | write data memory
    // BRANCH   | PC = PC + offset
    // MULSTART | issue start pulse to the multiply unit
    // MULWAIT  | wait for MulDone or timeout
    // MULWB    | write low / only product word
    // MULWBH   | write high product word (long multiplies)
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB, S_MEMADR, S_MEMRD,
        S_MEMWB, S_MEMWR, S_BRANCH, S_MULSTART, S_MULWAIT, S_MULWB, S_MULWBH
    } state_t;

    localparam logic [9:0] TMO_LOAD = 10'(MUL_TIMEOUT - 1);

    state_t     state, next_state;
    logic [3:0] flags;
    logic       cond_ex, cond_now;
    logic [9:0] tmo_cnt;

    logic [1:0] op;
    logic [3:0] cmd;
    logic [2:0] mul_kind;
    logic       imm_i, s_bit, rd15, is_cmp, upd_cv;
    logic       is_mul_enc, is_mul, mul_long, mul_signed, dp_ok, undef;
    logic [2:0] dp_ctl;
    logic       unused_bits;

    assign op         = Instr[27:26];
    assign imm_i      = Instr[25];
    assign cmd        = Instr[24:21];
    assign s_bit      = Instr[20];
    assign rd15       = (Instr[15:12] == 4'hF);
    assign mul_kind   = Instr[23:21];
    assign is_mul_enc = (op == 2'b00) && (Instr[25:24] == 2'b00) && (Instr[7:4] == 4'b1001);
    assign is_mul     = is_mul_enc && ENABLE_MUL &&
                        ((mul_kind == 3'b000) || (mul_kind == 3'b100) || (mul_kind == 3'b110));
    assign mul_long   = mul_kind[2];
    assign mul_signed = (mul_kind == 3'b110);
    assign is_cmp     = (cmd == 4'b1010);
    assign upd_cv     = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
    assign undef      = (op == 2'b11) || (is_mul_enc && !is_mul) ||
                        ((op == 2'b00) && !is_mul_enc && !dp_ok);
    assign unused_bits = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

    always_comb begin
        dp_ok  = 1'b1;
        dp_ctl = 3'b000;
        case (cmd)
            4'b0000: dp_ctl = 3'b010;
            4'b0001: dp_ctl = 3'b100;
            4'b0010: dp_ctl = 3'b001;
            4'b0100: dp_ctl = 3'b000;
            4'b1100: dp_ctl = 3'b011;
            4'b1101: dp_ctl = 3'b101;
            4'b1010: dp_ctl = 3'b001;
            default: dp_ok  = 1'b0;
        endcase
    end

    // flags = {N,Z,C,V}
    always_comb begin
        cond_now = 1'b0;
        case (Instr[31:28])
            4'h0: cond_now = flags[2];
            4'h1: cond_now = !flags[2];
            4'h2: cond_now = flags[1];
            4'h3: cond_now = !flags[1];
            4'h4: cond_now = flags[3];
            4'h5: cond_now = !flags[3];
            4'h6: cond_now = flags[0];
            4'h7: cond_now = !flags[0];
            4'h8: cond_now = flags[1] && !flags[2];
            4'h9: cond_now = !flags[1] || flags[2];
            4'hA: cond_now = (flags[3] == flags[0]);
            4'hB: cond_now = (flags[3] != flags[0]);
            4'hC: cond_now = !flags[2] && (flags[3] == flags[0]);
            4'hD: cond_now = flags[2] || (flags[3] != flags[0]);
            4'hE: cond_now = 1'b1;
            default: cond_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            flags   <= 4'b0000;
            cond_ex <= 1'b0;
            tmo_cnt <= 10'd0;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                cond_ex <= cond_now;
            // timeout is a down-counter: terminal count 0 marks the last allowed wait cycle
            if (state == S_MULSTART)
                tmo_cnt <= TMO_LOAD;
            else if ((state == S_MULWAIT) && (tmo_cnt != 10'd0))
                tmo_cnt <= tmo_cnt - 10'd1;
            if (((state == S_EXECR) || (state == S_EXECI)) && cond_ex && (s_bit || is_cmp)) begin
                flags[3:2] <= ALUFlags[3:2];
                if (upd_cv)
                    flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        MulRead    = 1'b0;
        WA3Src     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = 3'b000;
        MulStart   = 1'b0;
        MulSigned  = 1'b0;
        MulHi      = 1'b0;
        Fault      = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ImmSrc    = op;
                if (undef) begin
                    Fault      = 1'b1;
                    next_state = S_FETCH;
                end else if (!cond_now)  next_state = S_FETCH;
                else if (is_mul)         next_state = S_MULSTART;
                else if (op == 2'b01)    next_state = S_MEMADR;
                else if (op == 2'b10)    next_state = S_BRANCH;
                else if (imm_i)          next_state = S_EXECI;
                else                     next_state = S_EXECR;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = dp_ctl;
                next_state = is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                PCWrite    = cond_ex && rd15;
                RegWrite   = cond_ex && !rd15;
                next_state = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                next_state = s_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                AdrSrc     = 1'b1;
                ResultSrc  = 2'b01;
                PCWrite    = cond_ex && rd15;
                RegWrite   = cond_ex && !rd15;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                MemWrite   = cond_ex;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b10;
                ResultSrc  = 2'b10;
                PCWrite    = cond_ex;
                next_state = S_FETCH;
            end
            S_MULSTART: begin
                MulRead    = 1'b1;
                MulStart   = 1'b1;
                MulSigned  = mul_signed;
                next_state = S_MULWAIT;
            end
            S_MULWAIT: begin
                MulRead = 1'b1;
                if (MulDone)
                    next_state = S_MULWB;
                else if (tmo_cnt == 10'd0) begin
                    Fault      = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MULWB: begin
                ResultSrc  = 2'b11;
                RegWrite   = cond_ex;
                WA3Src     = !mul_long;
                next_state = mul_long ? S_MULWBH : S_FETCH;
            end
            S_MULWBH: begin
                ResultSrc  = 2'b11;
                MulHi      = 1'b1;
                WA3Src     = 1'b1;
                RegWrite   = cond_ex;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
            MulStart = 1'b0;
            Fault    = 1'b0;
        end
    end

endmodule

// File: doc/mc_seq_controller.md
# mc_seq_controller

Parametrised successor to the multicycle ARM controller. It merges the main-FSM decoder and condition logic into one sequential block, and adds an iterative multiply path (MUL/UMULL/SMULL) driven by a start/done handshake with a timeout. Failed-condition instructions take an early exit back to FETCH. Unsupported encodings raise a fault pulse. It sits between the instruction register and the multicycle datapath, and drives every mux select and write strobe.

## Interface
- ENABLE_MUL, 1: 1 decodes multiply encodings; 0 treats them as undefined.
- MUL_TIMEOUT, 64: maximum MULWAIT cycles before abort. Range 1..1023.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  32  instruction register contents.
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- MulDone  in  1  multiply unit result valid (level, sampled in MULWAIT only).
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  condition-gated write strobes.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register.
- RegSrc  out  2  [0]: RA1 = R15; [1]: RA2 = Instr[15:12].
- MulRead  out  1  RA1 = Instr[11:8], RA2 = Instr[3:0].
- WA3Src  out  1  write address: 0 = Instr[15:12], 1 = Instr[19:16].
- ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath selects. ResultSrc 11 = multiplier result.
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV(pass B).
- MulStart  out  1  one-cycle start pulse.
- MulSigned  out  1  SMULL.
- MulHi  out  1  select high product word.
- Fault  out  1  one-cycle pulse on undefined instruction or multiply timeout.

## Operation
- Decode fields:
  - Op = Instr[27:26]; I = Instr[25]; cmd = Instr[24:21]; S = Instr[20]; L = Instr[20].
  - Multiply when Op=00, Instr[25:24]=00, Instr[7:4]=1001.
  - Instr[23:21]: 000 MUL, 100 UMULL, 110 SMULL; other values are undefined.
- Data-processing cmds:
  - AND 0000, EOR 0001, SUB 0010, ADD 0100, ORR 1100, MOV 1101, CMP 1010 (SUB, no writeback).
  - Any other cmd, Op=11, or multiply with ENABLE_MUL=0 is undefined.
- Flag register {N,Z,C,V}, reset 0000. Updated at the end of EXECR/EXECI when S=1 and CondEx=1:
  - N,Z always.
  - C,V only for ADD/SUB/CMP.
  - CMP always updates flags.
- Condition codes:
  - CondEx is evaluated in DECODE from Instr[31:28] and the stored flags, using standard ARM codes 0000–1110.
  - Code 1111 evaluates false.
  - CondEx is registered and held until the next FETCH.
- State machine:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Always → DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ImmSrc=Op. Next state:
    - undefined → FETCH with Fault.
    - CondEx=0 → FETCH.
    - multiply → MULSTART.
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - otherwise EXECI if I=1, else EXECR.
  - EXECR (ALUSrcB=00) / EXECI (ALUSrcB=01): ALUSrcA=00 → ALUWB. CMP → FETCH.
  - ALUWB: ResultSrc=00, RegWrite. If Rd=15: PCWrite instead of RegWrite.
  - MEMADR: ALUSrcB=01, ADD. L=1 → MEMRD, L=0 → MEMWR.
  - MEMRD: AdrSrc=1 → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite (or PCWrite if Rd=15).
  - MEMWR: AdrSrc=1, MemWrite → FETCH.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite → FETCH.
  - MULSTART: MulRead=1, MulStart=1, MulSigned per op → MULWAIT. Timeout counter cleared.
  - MULWAIT: MulRead=1. Next state:
    - MulDone=1 → MULWB.
    - counter reaches MUL_TIMEOUT → FETCH with Fault and no writes.
    - otherwise increment the counter.
  - MULWB: ResultSrc=11.
    - MUL: MulHi=0, WA3Src=1, RegWrite → FETCH.
    - Long: MulHi=0, WA3Src=0 → MULWBH.
  - MULWBH: ResultSrc=11, MulHi=1, WA3Src=1, RegWrite → FETCH.
- Outputs not listed for a state are 0.

## Timing
- Reset:
  - State = FETCH, flags = 0, CondEx = 0, counter = 0.
  - While reset=1, all strobes (PCWrite, MemWrite, RegWrite, IRWrite, MulStart, Fault) are 0.
  - First FETCH strobes appear in the cycle after reset deasserts.
- Reset mid-instruction aborts the instruction with no further writes. A pending multiply result is ignored.
- Latency in cycles:
  - DP register/immediate: 4. CMP: 3.
  - LDR: 5. STR: 4.
  - B: 3.
  - Condition-failed: 2.
  - MUL: 4 + w. UMULL/SMULL: 5 + w, where w = MULWAIT cycles (at least 1).
- MulDone asserted in the first MULWAIT cycle gives w=1. MulDone outside MULWAIT is ignored.
- Timeout: Fault asserts in the MUL_TIMEOUT-th MULWAIT cycle, and the next state is FETCH.
- Rd=15 with RegW: PCWrite in the writeback cycle, RegWrite=0.

## Test plan
- Reset, then ADD R1,R2,R3 (E0821003) → states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4. ALUControl=000 in EXECR.
- SUBS producing ALUFlags 0100, then ADDEQ → ADDEQ takes 4 cycles with RegWrite. Same sequence with ALUFlags 0000 → 2-cycle skip, no strobes after FETCH.
- LDR (E5921004) → 5 cycles, AdrSrc=1 in MEMRD and MEMWB, ResultSrc=01 in MEMWB. STR → MemWrite pulse in cycle 4.
- UMULL (E0821394), MulDone after 3 cycles → MulStart pulse once, two RegWrite cycles with WA3Src 0 then 1 and MulHi 0 then 1. Total 8 cycles.
- MUL with MulDone held low, MUL_TIMEOUT=4 → Fault pulse after the 4th MULWAIT cycle, no RegWrite, return to FETCH. Same instruction with ENABLE_MUL=0 → Fault in DECODE.
- Reset asserted in MULWAIT → next cycle all strobes 0. After release, FETCH with flags 0000.
